// File: rtl/queue_25_pkg.sv
// TileLink D-channel field widths and the packed D-beat record shared by
// queue_25 and its neighbours.
package queue_25_pkg;

  localparam int TL_D_OPCODE_W  = 3;
  localparam int TL_D_PARAM_W   = 2;
  localparam int TL_D_SIZE_W    = 3;
  localparam int TL_D_SOURCE_W  = 3;
  localparam int TL_D_SINK_W    = 3;
  localparam int TL_D_DENIED_W  = 1;
  localparam int TL_D_DATA_W    = 64;
  localparam int TL_D_CORRUPT_W = 1;

  localparam int TL_D_BEAT_W = TL_D_OPCODE_W + TL_D_PARAM_W + TL_D_SIZE_W +
                               TL_D_SOURCE_W + TL_D_SINK_W + TL_D_DENIED_W +
                               TL_D_DATA_W + TL_D_CORRUPT_W;

  typedef struct packed {
    logic [TL_D_OPCODE_W-1:0]  opcode;
    logic [TL_D_PARAM_W-1:0]   param;
    logic [TL_D_SIZE_W-1:0]    size;
    logic [TL_D_SOURCE_W-1:0]  source;
    logic [TL_D_SINK_W-1:0]    sink;
    logic [TL_D_DENIED_W-1:0]  denied;
    logic [TL_D_DATA_W-1:0]    data;
    logic [TL_D_CORRUPT_W-1:0] corrupt;
  } d_beat_t;

endpackage

// File: rtl/queue_25.sv
// ENTRIES-deep FIFO of TileLink D beats; no flow-through, no pipe bypass.
// Handshake: a beat moves on a rising edge where valid and ready are both 1;
// ready/valid depend only on registered state, and a valid beat holds its
// payload until accepted.
module queue_25
  import queue_25_pkg::*;
#(
  parameter int ENTRIES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_enq_valid,
  output logic                      io_enq_ready,
  input  logic [TL_D_OPCODE_W-1:0]  io_enq_bits_opcode,
  input  logic [TL_D_PARAM_W-1:0]   io_enq_bits_param,
  input  logic [TL_D_SIZE_W-1:0]    io_enq_bits_size,
  input  logic [TL_D_SOURCE_W-1:0]  io_enq_bits_source,
  input  logic [TL_D_SINK_W-1:0]    io_enq_bits_sink,
  input  logic [TL_D_DENIED_W-1:0]  io_enq_bits_denied,
  input  logic [TL_D_DATA_W-1:0]    io_enq_bits_data,
  input  logic [TL_D_CORRUPT_W-1:0] io_enq_bits_corrupt,
  input  logic                      io_deq_ready,
  output logic                      io_deq_valid,
  output logic [TL_D_OPCODE_W-1:0]  io_deq_bits_opcode,
  output logic [TL_D_PARAM_W-1:0]   io_deq_bits_param,
  output logic [TL_D_SIZE_W-1:0]    io_deq_bits_size,
  output logic [TL_D_SOURCE_W-1:0]  io_deq_bits_source,
  output logic [TL_D_SINK_W-1:0]    io_deq_bits_sink,
  output logic [TL_D_DENIED_W-1:0]  io_deq_bits_denied,
  output logic [TL_D_DATA_W-1:0]    io_deq_bits_data,
  output logic [TL_D_CORRUPT_W-1:0] io_deq_bits_corrupt
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  d_beat_t          entries_q [ENTRIES];
  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;

  logic    ptr_match, empty, full, do_enq, do_deq;
  d_beat_t enq_beat, deq_beat;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  assign io_enq_ready = ~full;
  assign io_deq_valid = ~empty;

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_ready & io_deq_valid;

  assign enq_beat = '{opcode:  io_enq_bits_opcode,
                      param:   io_enq_bits_param,
                      size:    io_enq_bits_size,
                      source:  io_enq_bits_source,
                      sink:    io_enq_bits_sink,
                      denied:  io_enq_bits_denied,
                      data:    io_enq_bits_data,
                      corrupt: io_enq_bits_corrupt};

  // Storage is deliberately unreset; the pointers alone decide what is live.
  always_ff @(posedge clock) begin
    if (do_enq) entries_q[enq_ptr] <= enq_beat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) enq_ptr <= enq_ptr + PTR_W'(1);
      if (do_deq) deq_ptr <= deq_ptr + PTR_W'(1);
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end

  assign deq_beat = entries_q[deq_ptr];

  assign io_deq_bits_opcode  = deq_beat.opcode;
  assign io_deq_bits_param   = deq_beat.param;
  assign io_deq_bits_size    = deq_beat.size;
  assign io_deq_bits_source  = deq_beat.source;
  assign io_deq_bits_sink    = deq_beat.sink;
  assign io_deq_bits_denied  = deq_beat.denied;
  assign io_deq_bits_data    = deq_beat.data;
  assign io_deq_bits_corrupt = deq_beat.corrupt;

endmodule

// File: tb/tb_queue_25.sv
// Bench for queue_25: directed scenarios then random traffic, every cycle
// compared against a queue-based model of a 2-entry FIFO.
module tb_queue_25;

  localparam int DEPTH = 2;
  localparam int REC_W = 80;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_enq_valid = 1'b0;
  logic        io_enq_ready;
  logic [2:0]  io_enq_bits_opcode = '0;
  logic [1:0]  io_enq_bits_param = '0;
  logic [2:0]  io_enq_bits_size = '0;
  logic [2:0]  io_enq_bits_source = '0;
  logic [2:0]  io_enq_bits_sink = '0;
  logic [0:0]  io_enq_bits_denied = '0;
  logic [63:0] io_enq_bits_data = '0;
  logic [0:0]  io_enq_bits_corrupt = '0;
  logic        io_deq_ready = 1'b0;
  logic        io_deq_valid;
  logic [2:0]  io_deq_bits_opcode;
  logic [1:0]  io_deq_bits_param;
  logic [2:0]  io_deq_bits_size;
  logic [2:0]  io_deq_bits_source;
  logic [2:0]  io_deq_bits_sink;
  logic [0:0]  io_deq_bits_denied;
  logic [63:0] io_deq_bits_data;
  logic [0:0]  io_deq_bits_corrupt;

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] deq_rec;
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  assign deq_rec = {io_deq_bits_opcode, io_deq_bits_param, io_deq_bits_size,
                    io_deq_bits_source, io_deq_bits_sink, io_deq_bits_denied,
                    io_deq_bits_data, io_deq_bits_corrupt};

  queue_25 #(.ENTRIES(DEPTH)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_enq_valid        (io_enq_valid),
    .io_enq_ready        (io_enq_ready),
    .io_enq_bits_opcode  (io_enq_bits_opcode),
    .io_enq_bits_param   (io_enq_bits_param),
    .io_enq_bits_size    (io_enq_bits_size),
    .io_enq_bits_source  (io_enq_bits_source),
    .io_enq_bits_sink    (io_enq_bits_sink),
    .io_enq_bits_denied  (io_enq_bits_denied),
    .io_enq_bits_data    (io_enq_bits_data),
    .io_enq_bits_corrupt (io_enq_bits_corrupt),
    .io_deq_ready        (io_deq_ready),
    .io_deq_valid        (io_deq_valid),
    .io_deq_bits_opcode  (io_deq_bits_opcode),
    .io_deq_bits_param   (io_deq_bits_param),
    .io_deq_bits_size    (io_deq_bits_size),
    .io_deq_bits_source  (io_deq_bits_source),
    .io_deq_bits_sink    (io_deq_bits_sink),
    .io_deq_bits_denied  (io_deq_bits_denied),
    .io_deq_bits_data    (io_deq_bits_data),
    .io_deq_bits_corrupt (io_deq_bits_corrupt)
  );

  // Clock / reset
  always #5 clock = ~clock;

  function automatic logic [REC_W-1:0] mk_rec(input logic [2:0] opcode,
                                              input logic [2:0] source,
                                              input logic [63:0] data);
    return {opcode, 2'd0, 3'd0, source, 3'd0, 1'b0, data, 1'b0};
  endfunction

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r;
    r = {$urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic check(input string tag, input logic [REC_W-1:0] obs,
                       input logic [REC_W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: drive after the falling edge, compare, then let the model follow
  // the rising edge using only its own occupancy.
  task automatic step(input string tag, input bit ev, input bit dr,
                      input logic [REC_W-1:0] rec);
    bit acc, pop;
    @(negedge clock);
    io_enq_valid = ev;
    io_deq_ready = dr;
    {io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
     io_enq_bits_source, io_enq_bits_sink, io_enq_bits_denied,
     io_enq_bits_data, io_enq_bits_corrupt} = rec;
    #1;
    check({tag, ".enq_ready"}, REC_W'(io_enq_ready), REC_W'(exp_q.size() < DEPTH));
    check({tag, ".deq_valid"}, REC_W'(io_deq_valid), REC_W'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, ".deq_bits"}, deq_rec, exp_q[0]);
    acc = ev && (exp_q.size() < DEPTH);
    pop = dr && (exp_q.size() != 0);
    @(posedge clock);
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(rec);
  endtask

  // Reset asserted for one edge while also offering traffic; reset must win.
  task automatic do_reset(input bit ev, input bit dr);
    @(negedge clock);
    reset = 1'b1;
    io_enq_valid = ev;
    io_deq_ready = dr;
    io_enq_bits_data = 64'hDEAD_BEEF;
    @(posedge clock);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
  endtask

  initial begin
    do_reset(1'b0, 1'b0);
    do_reset(1'b1, 1'b1);

    // Idle after reset
    step("idle", 1'b0, 1'b0, '0);
    step("idle2", 1'b0, 1'b0, '0);

    // Single beat, no flow-through
    step("one_enq", 1'b1, 1'b0, mk_rec(3'd1, 3'd2, 64'h1111));
    step("one_hold", 1'b0, 1'b0, '0);
    step("one_deq", 1'b0, 1'b1, '0);
    step("one_empty", 1'b0, 1'b0, '0);

    // Fill, then offer a third beat while draining
    step("fill_a", 1'b1, 1'b0, mk_rec(3'd0, 3'd0, 64'hA));
    step("fill_b", 1'b1, 1'b0, mk_rec(3'd0, 3'd0, 64'hB));
    step("full_c0", 1'b1, 1'b0, mk_rec(3'd0, 3'd0, 64'hC));
    step("full_c1", 1'b1, 1'b1, mk_rec(3'd0, 3'd0, 64'hC));
    step("drain_b", 1'b0, 1'b1, '0);
    step("drained", 1'b0, 1'b0, '0);

    // Full queue drained over two cycles
    step("fill2_a", 1'b1, 1'b0, mk_rec(3'd0, 3'd0, 64'hA));
    step("fill2_b", 1'b1, 1'b0, mk_rec(3'd0, 3'd0, 64'hB));
    step("out_a", 1'b0, 1'b1, '0);
    step("out_b", 1'b0, 1'b1, '0);
    step("out_empty", 1'b0, 1'b0, '0);

    // Streaming across pointer wrap
    for (int i = 0; i < 8; i++)
      step("stream", 1'b1, 1'b1, mk_rec(3'd0, 3'd0, 64'(i)));
    step("stream_tail", 1'b0, 1'b1, '0);
    step("stream_end", 1'b0, 1'b0, '0);

    // Reset with a record queued discards it
    step("pre_rst", 1'b1, 1'b0, mk_rec(3'd4, 3'd5, 64'h5555));
    do_reset(1'b1, 1'b1);
    step("post_rst", 1'b0, 1'b1, '0);
    step("post_rst2", 1'b1, 1'b0, mk_rec(3'd6, 3'd1, 64'h7777));
    step("post_rst3", 1'b0, 1'b1, '0);
    step("post_rst4", 1'b0, 1'b0, '0);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0)
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
             rand_rec());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
